// File: rtl/clock_display_pkg.sv
// clock_display_pkg: shared widths, slot order, segment patterns and Johnson code check
package clock_display_pkg;
  localparam int JOHNSON_W  = 10;
  localparam int NUM_DIGITS = 6;
  typedef enum logic [2:0] {SLOT_S0, SLOT_S1, SLOT_M0, SLOT_M1, SLOT_H0, SLOT_H1} slot_e;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  function automatic logic johnson_valid(input logic [JOHNSON_W-1:0] c);
    return ((c & (c + JOHNSON_W'(1))) == '0) && (c != '1);
  endfunction
endpackage

// File: rtl/johnson_digit_decode.sv
// johnson_digit_decode: Johnson digit code to binary value plus validity
module johnson_digit_decode
  import clock_display_pkg::*;
(
  input  logic [JOHNSON_W-1:0] code_i,
  output logic [3:0]           value_o,
  output logic                 valid_o
);
  assign valid_o = johnson_valid(code_i);
  assign value_o = 4'($countones(code_i));
endmodule

// File: rtl/display_mux_johnson.sv
// display_mux_johnson: frame-snapshotted six-digit multiplexed 7-segment driver with ghosting guard
module display_mux_johnson
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [JOHNSON_W-1:0] H_in1_johnson,
  input  logic [JOHNSON_W-1:0] H_in0_johnson,
  input  logic [JOHNSON_W-1:0] M_in1_johnson,
  input  logic [JOHNSON_W-1:0] M_in0_johnson,
  input  logic [JOHNSON_W-1:0] S_in1_johnson,
  input  logic [JOHNSON_W-1:0] S_in0_johnson,
  input  logic                 reg_0_15s,
  input  logic                 reg_15_30s,
  input  logic                 reg_30_45s,
  input  logic                 reg_45_59s,
  input  logic                 blank_lz,
  output logic [6:0]           seg,
  output logic [5:0]           an,
  output logic                 dp,
  output logic                 code_err
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0]        presc_q;
  slot_e                slot_q, slot_d;
  logic [JOHNSON_W-1:0] snap_q [NUM_DIGITS];
  logic [JOHNSON_W-1:0] live [NUM_DIGITS];
  logic [3:0]           quad_q;
  logic                 blank_lz_q, blank_q, blank_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d, err_q, any_bad;
  logic                 tc, frame_start;
  logic [JOHNSON_W-1:0] sel_code;
  logic [3:0]           dec_val;
  logic                 dec_valid;
  assign live = '{S_in0_johnson, S_in1_johnson, M_in0_johnson, M_in1_johnson, H_in0_johnson, H_in1_johnson};
  assign tc          = presc_q == PW'(SCAN_DIV - 1);
  assign frame_start = tc && slot_q == SLOT_H1;
  // Outputs for the next slot are prepared at terminal count; slot 0 reads the values being snapshotted.
  always_comb begin
    slot_d   = slot_q == SLOT_H1 ? SLOT_S0 : slot_e'(slot_q + 3'd1);
    sel_code = slot_q == SLOT_H1 ? live[SLOT_S0] : snap_q[slot_d];
    dp_d     = slot_d < SLOT_H0 ? ~(slot_q == SLOT_H1 ? reg_0_15s : quad_q[slot_d[1:0]]) : 1'b1;
    blank_d  = slot_d == SLOT_H1 && blank_lz_q && dec_valid && dec_val == 4'd0;
    seg_d    = blank_d ? SEG_BLANK : !dec_valid ? SEG_DASH : SEG_DIGIT[dec_val];
    any_bad  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) any_bad |= !johnson_valid(live[i]);
  end
  johnson_digit_decode u_dec (
    .code_i  (sel_code),
    .value_o (dec_val),
    .valid_o (dec_valid)
  );
  // blank_q resets high so the pre-frame slot after reset never lights a digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      slot_q     <= SLOT_H1;
      snap_q     <= '{default: '0};
      quad_q     <= '0;
      blank_lz_q <= 1'b0;
      blank_q    <= 1'b1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      presc_q <= tc ? '0 : presc_q + PW'(1);
      if (tc) begin
        slot_q  <= slot_d;
        seg_q   <= seg_d;
        dp_q    <= dp_d;
        blank_q <= blank_d;
      end
      if (frame_start) begin
        snap_q     <= live;
        quad_q     <= {reg_45_59s, reg_30_45s, reg_15_30s, reg_0_15s};
        blank_lz_q <= blank_lz;
        err_q      <= any_bad;
      end
    end
  end
  assign an       = (presc_q == '0 || blank_q) ? '1 : ~(6'(1) << slot_q);
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign code_err = err_q;
endmodule

// File: tb/tb_display_mux_johnson.sv
// tb_display_mux_johnson: randomized and directed checks against a frame-level reference model
module tb_display_mux_johnson;
  localparam int DIV   = 4;
  localparam int FRAME = 6 * DIV;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] code [6];
  logic [3:0] quad;
  logic       blank_lz;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp, code_err;
  logic [9:0] m_code [6];
  logic [3:0] m_quad;
  logic       m_blank;
  int         n, passed, total;
  logic [6:0] seg_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  always #5 clk = ~clk;
  display_mux_johnson #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .H_in1_johnson(code[5]), .H_in0_johnson(code[4]),
    .M_in1_johnson(code[3]), .M_in0_johnson(code[2]),
    .S_in1_johnson(code[1]), .S_in0_johnson(code[0]),
    .reg_0_15s(quad[0]), .reg_15_30s(quad[1]), .reg_30_45s(quad[2]), .reg_45_59s(quad[3]),
    .blank_lz(blank_lz), .seg(seg), .an(an), .dp(dp), .code_err(code_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s n=%0d: got %0h expected %0h", tag, n, got, exp);
  endtask
  function automatic int dval(input logic [9:0] c);
    for (int d = 0; d < 10; d++) if (c == 10'((1 << d) - 1)) return d;
    return -1;
  endfunction
  task automatic compare();
    logic [6:0] es;
    logic [5:0] ea;
    logic       ed, ee, blank;
    int         s, p, d;
    if (n < DIV) begin
      es = 7'h7F; ea = 6'h3F; ed = 1'b1; ee = 1'b0;
    end else begin
      s     = ((n / DIV) - 1) % 6;
      p     = n % DIV;
      d     = dval(m_code[s]);
      blank = (s == 5) && m_blank && (d == 0);
      es    = blank ? 7'h7F : (d < 0) ? 7'h3F : ~seg_hi[d];
      ea    = (p == 0 || blank) ? 6'h3F : ~(6'b1 << s);
      ed    = (s < 4) ? ~m_quad[s] : 1'b1;
      ee    = 1'b0;
      for (int i = 0; i < 6; i++) if (dval(m_code[i]) < 0) ee = 1'b1;
    end
    check("an", 32'(an), 32'(ea));
    check("seg", 32'(seg), 32'(es));
    check("dp", 32'(dp), 32'(ed));
    check("code_err", 32'(code_err), 32'(ee));
  endtask
  function automatic logic [9:0] pick(input int k);
    int r = $urandom_range(0, 9);
    if (r == 0) return 10'($urandom);
    if (r == 1) return 10'h3FF;
    if (r < 4 && k == 5) return 10'h000;
    return 10'((1 << $urandom_range(0, 9)) - 1);
  endfunction
  task automatic randomize_one();
    int k = $urandom_range(0, 11);
    if (k < 6) code[k] = pick(k);
    else if (k < 10) quad[k-6] = 1'($urandom);
    else blank_lz = 1'($urandom);
  endtask
  task automatic run(input int k, input bit rnd);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      if (reset) begin
        n++;
        if (n >= DIV && (n - DIV) % FRAME == 0) begin
          m_code  = code;
          m_quad  = quad;
          m_blank = blank_lz;
        end
      end
      #1;
      compare();
      if (rnd && $urandom_range(0, 5) == 0) randomize_one();
    end
  endtask
  task automatic model_reset();
    n = 0;
    m_code  = '{default: '0};
    m_quad  = '0;
    m_blank = 1'b0;
  endtask
  initial begin
    passed = 0;
    total  = 0;
    model_reset();
    code = '{10'h03F, 10'h01F, 10'h00F, 10'h007, 10'h003, 10'h001};
    quad = '0;
    blank_lz = 1'b0;
    run(3, 0);
    @(negedge clk) reset = 1'b1;
    run(DIV + 2 * FRAME, 0);
    code[0] = 10'h005;
    run(FRAME, 0);
    code[0] = 10'h03F;
    run(2 * FRAME, 0);
    quad = 4'b0100;
    run(2 * FRAME, 0);
    quad = '0;
    code[5] = 10'h000;
    blank_lz = 1'b1;
    run(2 * FRAME, 0);
    blank_lz = 1'b0;
    run(2 * FRAME, 0);
    code[2] = 10'h000;
    run(FRAME + DIV, 0);
    code[2] = 10'h001;
    run(2 * FRAME - DIV, 0);
    run(5, 0);
    reset = 1'b0;
    model_reset();
    #1;
    compare();
    run(2, 0);
    @(negedge clk) reset = 1'b1;
    run(DIV + 30 * FRAME, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
